// File: rtl/wbdebug_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge: command codes,
// FSM state encoding and the default write-acknowledge byte.
package wbdebug_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h01;
    localparam logic [7:0] CMD_READ       = 8'h02;
    localparam logic [7:0] WR_ACK_DEFAULT = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADR    = 3'd1,
        S_DATW   = 3'd2,
        S_WB     = 3'd3,
        S_TX     = 3'd4,
        S_TXWAIT = 3'd5
    } state_e;

endpackage

// File: rtl/wbdebug.sv
// UART byte-stream to Wishbone master bridge: parses read/write frames,
// runs one classic bus cycle and returns the result over the UART.
module wbdebug
    import wbdebug_pkg::*;
#(
    parameter logic [23:0] rx_timeout  = 24'd1000000,
    parameter logic [7:0]  wr_ack_byte = WR_ACK_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_stb,
    input  logic        tx_done,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        is_wr_q;
    logic [23:0] tmo_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rdat_q;
    logic [7:0]  tx_data_q;
    logic        tx_stb_q;
    logic        cyc_q;
    logic        we_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            is_wr_q   <= 1'b0;
            tmo_q     <= 24'd0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            rdat_q    <= 32'd0;
            tx_data_q <= 8'd0;
            tx_stb_q  <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            tx_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_stb && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        is_wr_q <= (rx_data == CMD_WRITE);
                        cnt_q   <= 2'd0;
                        tmo_q   <= 24'd0;
                        state_q <= S_ADR;
                    end
                end
                S_ADR, S_DATW: begin
                    // A byte landing on the expiry cycle still wins over the timeout
                    if (rx_stb) begin
                        tmo_q <= 24'd0;
                        cnt_q <= cnt_q + 2'd1;
                        if (state_q == S_ADR) adr_q <= {adr_q[23:0], rx_data};
                        else                  dat_q <= {dat_q[23:0], rx_data};
                        if (cnt_q == 2'd3) begin
                            if (state_q == S_ADR && is_wr_q) begin
                                state_q <= S_DATW;
                            end else begin
                                state_q <= S_WB;
                                cyc_q   <= 1'b1;
                                we_q    <= is_wr_q;
                            end
                        end
                    end else if (tmo_q == rx_timeout - 24'd1) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 24'd1;
                    end
                end
                S_WB: begin
                    if (wb_ack_i) begin
                        cyc_q     <= 1'b0;
                        we_q      <= 1'b0;
                        cnt_q     <= 2'd0;
                        rdat_q    <= wb_dat_i;
                        tx_data_q <= is_wr_q ? wr_ack_byte : wb_dat_i[31:24];
                        tx_stb_q  <= 1'b1;
                        state_q   <= S_TX;
                    end
                end
                S_TX: state_q <= S_TXWAIT;
                S_TXWAIT: begin
                    if (tx_done) begin
                        if (is_wr_q || cnt_q == 2'd3) begin
                            state_q <= S_IDLE;
                        end else begin
                            // rdat_q is consumed MSB first by shifting left
                            cnt_q     <= cnt_q + 2'd1;
                            rdat_q    <= {rdat_q[23:0], 8'd0};
                            tx_data_q <= rdat_q[23:16];
                            tx_stb_q  <= 1'b1;
                            state_q   <= S_TX;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_stb   = tx_stb_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = cyc_q ? 4'hf : 4'h0;
    assign wb_cti_o = 3'b000;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wbdebug.sv
// Scoreboard bench for wbdebug: frames push expected bus cycles and tx bytes,
// slave/transmitter models pop and compare them as the bridge produces output.
module tb_wbdebug;
    import wbdebug_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_done = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    wbdebug #(.rx_timeout(24'd100)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .rx_data(rx_data), .rx_stb(rx_stb),
        .tx_data(tx_data), .tx_stb(tx_stb), .tx_done(tx_done),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } wb_exp_t;

    wb_exp_t     wbq[$];
    logic [7:0]  txq[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] rd_val = 32'd0;
    int          ws_n = 0;
    int          ws_cnt = 0;
    bit          ack_en = 1'b1;
    bit          in_cyc = 1'b0;
    logic [31:0] cur_adr = 32'd0;
    bit          tx_busy = 1'b0;
    int          tx_cnt = 0;
    logic [7:0]  cur_tx = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave in one process so the monitor sees the ack the DUT sampled
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (wb_ack_i) begin
                chk("wb_drop", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
            end else if (wb_cyc_o && !in_cyc) begin
                in_cyc  = 1'b1;
                cur_adr = wb_adr_o;
                if (wbq.size() == 0) begin
                    chk("wb_unexp", 32'd1, 32'd0);
                end else begin
                    e = wbq.pop_front();
                    chk("wb_adr", wb_adr_o, e.adr);
                    chk("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
                    chk("wb_sel", {28'd0, wb_sel_o}, 32'hf);
                    chk("wb_cti", {29'd0, wb_cti_o}, 32'd0);
                    chk("wb_stb", {31'd0, wb_stb_o}, 32'd1);
                    if (e.we) chk("wb_dat", wb_dat_o, e.dat);
                end
            end else if (wb_cyc_o) begin
                chk("wb_hold", wb_adr_o, cur_adr);
            end
            if (!wb_cyc_o) in_cyc = 1'b0;

            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
            end else if (wb_cyc_o && wb_stb_o && ack_en) begin
                if (ws_cnt == ws_n) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rd_val;
                    ws_cnt   = 0;
                end else begin
                    ws_cnt++;
                end
            end else if (!wb_cyc_o) begin
                ws_cnt = 0;
            end
        end
    end

    // UART transmitter model: takes 7 cycles per byte
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_stb) begin
                chk("tx_overlap", {31'd0, tx_busy}, 32'd0);
                if (txq.size() == 0) chk("tx_unexp", {24'd0, tx_data}, 32'hffff_ffff);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, txq.pop_front()});
                cur_tx  = tx_data;
                tx_busy = 1'b1;
                tx_cnt  = 6;
            end else if (tx_busy) begin
                if (tx_cnt == 0) begin
                    chk("tx_hold", {24'd0, tx_data}, {24'd0, cur_tx});
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end else begin
                    tx_cnt--;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int extra);
        repeat (extra) @(negedge clk);
        @(negedge clk);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] adr, input logic [31:0] dat, input bit exp_tx);
        wb_exp_t e;
        e.adr = adr; e.dat = dat; e.we = 1'b1;
        wbq.push_back(e);
        if (exp_tx) txq.push_back(WR_ACK_DEFAULT);
        ws_n = 0;
        send_byte(CMD_WRITE, 0);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 0);
        for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], 0);
    endtask

    task automatic send_read(input logic [31:0] adr, input logic [31:0] rd, input int ws);
        wb_exp_t e;
        e.adr = adr; e.dat = 32'd0; e.we = 1'b0;
        wbq.push_back(e);
        for (int i = 3; i >= 0; i--) txq.push_back(rd[8*i +: 8]);
        rd_val = rd;
        ws_n   = ws;
        send_byte(CMD_READ, 0);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 0);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((busy || wbq.size() != 0 || txq.size() != 0 || tx_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, {31'd0, t < 3000}, 32'd1);
    endtask

    initial begin
        int t;
        wb_exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("rst_tx", {23'd0, tx_stb, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send_write(32'h4000_0010, 32'hDEAD_BEEF, 1'b1);
        wait_idle("idle_write");

        send_read(32'h2000_0004, 32'h1234_5678, 3);
        wait_idle("idle_read");

        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h7E, 0);
        chk("garbage_busy", {31'd0, busy}, 32'd0);
        send_read(32'h0000_0101, 32'hA5A5_5A5A, 0);
        wait_idle("idle_garbage");

        // 100 idle cycles after the partial frame expire it before the read command
        send_byte(CMD_WRITE, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        send_byte(CMD_READ, 99);
        wbq.push_back('{adr: 32'h1000_0020, dat: 32'd0, we: 1'b0});
        for (int i = 3; i >= 0; i--) txq.push_back(rd_val[8*i +: 8]);
        rd_val = 32'h0BAD_F00D;
        txq.delete();
        for (int i = 3; i >= 0; i--) txq.push_back(rd_val[8*i +: 8]);
        ws_n = 2;
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        wait_idle("idle_timeout");

        // 99 idle cycles: the byte arrives on the expiry cycle and is kept
        e.adr = 32'hAABB_CCDD; e.dat = 32'h1122_3344; e.we = 1'b1;
        wbq.push_back(e);
        txq.push_back(WR_ACK_DEFAULT);
        ws_n = 1;
        send_byte(CMD_WRITE, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 98);
        for (int i = 3; i >= 0; i--) send_byte(e.dat[8*i +: 8], 0);
        wait_idle("idle_edge");

        send_read(32'h3000_0008, 32'hCAFE_F00D, 1);
        t = 0;
        while (!tx_stb && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stray_wait", {31'd0, t < 200}, 32'd1);
        send_byte(CMD_WRITE, 0);
        send_byte(CMD_READ, 0);
        send_byte(8'h55, 0);
        wait_idle("idle_stray");
        chk("stray_busy", {31'd0, busy}, 32'd0);

        ack_en = 1'b0;
        send_write(32'h5000_0000, 32'h0000_00FF, 1'b0);
        t = 0;
        while (!wb_cyc_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("abort_cyc_seen", {31'd0, wb_cyc_o}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_tx", {31'd0, tx_stb}, 32'd0);
        chk("abort_adr", wb_adr_o, 32'd0);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        send_read(32'h6000_000C, 32'h8765_4321, 0);
        wait_idle("idle_recover");
        chk("wbq_empty", wbq.size(), 32'd0);
        chk("txq_empty", txq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wbdebug.md
WBDEBUG -- requirements
Module: wbdebug

Interface
REQ-001 Parameter: rx_timeout, default 24'd1000000, idle sys_clk cycles allowed between bytes of one frame.
REQ-002 Parameter: wr_ack_byte, default 8'h06, byte returned after a completed write.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received byte from UART receiver.
REQ-006 rx_stb  in  1  one-cycle pulse, rx_data valid.
REQ-007 tx_data  out  8  byte to UART transmitter.
REQ-008 tx_stb  out  1  one-cycle pulse, start sending tx_data.
REQ-009 tx_done  in  1  one-cycle pulse, transmitter finished the current byte.
REQ-010 wb_adr_o  out  32  Wishbone address.
REQ-011 wb_dat_o  out  32  Wishbone write data.
REQ-012 wb_dat_i  in  32  Wishbone read data.
REQ-013 wb_sel_o  out  4  byte selects; always 4'hf during a cycle.
REQ-014 wb_cti_o  out  3  always 3'b000 (classic cycle).
REQ-015 wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone master controls.
REQ-016 wb_ack_i  in  1  Wishbone acknowledge.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 Frame format: command byte, then 4 address bytes MSB first; write command (8'h01) then 4 data bytes MSB first; read command (8'h02) has no data bytes.
REQ-019 States: IDLE, ADR, DATW, WB, TX, TXWAIT.
REQ-020 IDLE: rx_stb with 8'h01 or 8'h02 -> ADR, byte counter = 0; any other byte discarded, remain IDLE.
REQ-021 ADR: each rx_stb shifts the byte into the address register LSB end; on 4th byte -> DATW (write) or WB (read).
REQ-022 DATW: each rx_stb shifts into the data register; on 4th byte -> WB.
REQ-023 WB: wb_cyc_o = wb_stb_o = 1 starting the cycle after the final frame byte is accepted; wb_we_o = 1 for write; outputs held stable until wb_ack_i is sampled high.
REQ-024 On wb_ack_i: cyc/stb/we deassert next cycle; read latches wb_dat_i in the same cycle; -> TX.
REQ-025 No Wishbone timeout; WB waits indefinitely for ack.
REQ-026 TX: tx_stb pulses for exactly one cycle with tx_data valid; tx_data held until tx_done; -> TXWAIT.
REQ-027 TXWAIT: on tx_done, either -> TX for the next byte (read: 4 bytes MSB first) or -> IDLE after the last byte (write: single wr_ack_byte).
REQ-028 Next tx_stb occurs no earlier than the cycle after tx_done.
REQ-029 rx_stb in WB, TX or TXWAIT is ignored (byte dropped, no state change).
REQ-030 In ADR/DATW, an inter-byte gap of rx_timeout cycles without rx_stb -> IDLE, partial frame discarded, no bus cycle, no response.
REQ-031 The timeout counter resets on every accepted byte; a byte arriving in the same cycle as expiry is accepted (the byte wins).
REQ-032 Address passes through unmodified (byte address, no alignment check).

Reset
REQ-033 On sys_rst: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, tx_stb, busy = 0; wb_adr_o, wb_dat_o, tx_data = 0; counters 0.
REQ-034 Reset during WB deasserts cyc/stb the following cycle regardless of wb_ack_i; the transaction is abandoned with no response.
REQ-035 Reset during TX/TXWAIT abandons the remaining response bytes.

Structure
REQ-036 Shared package holds the command codes (8'h01, 8'h02), the state encoding and the default wr_ack_byte.
REQ-037 Single module, no sub-modules; data and address shift registers are local.

Verification
REQ-038 Write: bytes 01 40 00 00 10 DE AD BE EF -> one cycle, adr 32'h40000010, dat 32'hDEADBEEF, we=1, sel=f; after ack, single tx byte 06.
REQ-039 Read: 02 20 00 00 04, slave acks with 32'h12345678 after 3 wait states -> tx bytes 12 34 56 78 in order, each tx_stb only after the previous tx_done.
REQ-040 Garbage: bytes 00 FF 7E then a valid read -> the first three are ignored, exactly one read cycle occurs.
REQ-041 Timeout (rx_timeout=100): 01 40 00, gap of 100 cycles, then 02 … -> no bus cycle for the partial frame; the new read proceeds normally.
REQ-042 Reset with wb_cyc_o high and ack withheld -> cyc/stb low next cycle; no tx_stb; busy=0.
REQ-043 rx_stb pulses during TXWAIT of a read -> dropped; response bytes unchanged; returns to IDLE.
